// File: rtl/out_port_arb_if.sv
// Bundle of the per-input flit channels and the single output channel of
// the output-port arbiter.
//
// Handshake: a flit moves across a channel on a rising clk edge where its
// valid and ready are both high. A source holds valid and the flit stable
// until that edge; ready may depend combinationally on valid.
interface out_port_arb_if #(
  parameter int N_OF_INPUTS = 2,
  parameter int FLIT_WIDTH  = 34
);
  logic [N_OF_INPUTS-1:0]            in_valid_i;
  logic [N_OF_INPUTS*FLIT_WIDTH-1:0] in_flit_i;
  logic [N_OF_INPUTS-1:0]            in_ready_o;
  logic                              out_valid_o;
  logic [FLIT_WIDTH-1:0]             out_flit_o;
  logic                              out_ready_i;
  logic                              busy_o;

  // Arbiter side
  modport slave (
    input  in_valid_i, in_flit_i, out_ready_i,
    output in_ready_o, out_valid_o, out_flit_o, busy_o
  );

  // Environment side (sources and downstream sink)
  modport master (
    output in_valid_i, in_flit_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_flit_o, busy_o
  );
endinterface

// File: rtl/out_port_arb.sv
// Wormhole output-port arbiter: round-robin among inputs presenting a head
// flit, then locks onto the winner until its tail passes. The output is one
// register stage with a bubble-free load enable.
module out_port_arb #(
  parameter int N_OF_INPUTS = 2,
  parameter int FLIT_WIDTH  = 34
) (
  input  logic           clk,
  input  logic           arst_n,
  out_port_arb_if.slave  bus
);

  localparam int IDX_W = (N_OF_INPUTS > 1) ? $clog2(N_OF_INPUTS) : 1;

  localparam logic [1:0] T_HEAD      = 2'b00;
  localparam logic [1:0] T_TAIL      = 2'b10;
  localparam logic [1:0] T_HEAD_TAIL = 2'b11;

  // The FSM state is visible outside through busy_o (high in LOCKED).
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [N_OF_INPUTS-1:0]  mask_q, mask_d;
  logic [IDX_W-1:0]        lock_q, lock_d;
  logic                    out_valid_q;
  logic [FLIT_WIDTH-1:0]   out_flit_q;

  logic [FLIT_WIDTH-1:0]   flit  [N_OF_INPUTS];
  logic [1:0]              ftype [N_OF_INPUTS];
  logic [N_OF_INPUTS-1:0]  req, mask_req, pick, ready;
  logic [IDX_W-1:0]        gnt;
  logic                    ld, xfer;
  logic [FLIT_WIDTH-1:0]   sel_flit;

  // Unpack the flat flit bus and pick out each flit's type field.
  always_comb begin
    for (int k = 0; k < N_OF_INPUTS; k++) begin
      flit[k]  = bus.in_flit_i[k*FLIT_WIDTH +: FLIT_WIDTH];
      ftype[k] = flit[k][FLIT_WIDTH-1 -: 2];
    end
  end

  // Round-robin pick among head requests: lowest index above the last
  // winner first, wrapping to the lowest requester when none is above.
  always_comb begin
    for (int k = 0; k < N_OF_INPUTS; k++) begin
      req[k] = bus.in_valid_i[k] &&
               (ftype[k] == T_HEAD || ftype[k] == T_HEAD_TAIL);
    end
    mask_req = mask_q & req;
    pick     = (|mask_req) ? mask_req : req;
    gnt      = '0;
    for (int k = N_OF_INPUTS - 1; k >= 0; k--) begin
      if (pick[k]) gnt = IDX_W'(k);
    end
  end

  // Next-state, accept and output-load decisions for IDLE/LOCKED.
  always_comb begin
    ld       = !out_valid_q || bus.out_ready_i;
    ready    = '0;
    xfer     = 1'b0;
    sel_flit = '0;
    state_d  = state_q;
    mask_d   = mask_q;
    lock_d   = lock_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          ready[gnt] = ld;
          if (ld) begin
            xfer     = 1'b1;
            sel_flit = flit[gnt];
            for (int k = 0; k < N_OF_INPUTS; k++) begin
              mask_d[k] = (IDX_W'(k) > gnt);
            end
            if (ftype[gnt] == T_HEAD) begin
              state_d = LOCKED;
              lock_d  = gnt;
            end
          end
        end
      end
      LOCKED: begin
        // Stray heads here are plain payload: no state or mask change.
        ready[lock_q] = ld;
        if (ld && bus.in_valid_i[lock_q]) begin
          xfer     = 1'b1;
          sel_flit = flit[lock_q];
          if (ftype[lock_q] == T_TAIL) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, mask, lock index and the output register stage.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      mask_q      <= '1;
      lock_q      <= '0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      lock_q  <= lock_d;
      if (ld) begin
        out_valid_q <= xfer;
        if (xfer) out_flit_q <= sel_flit;
      end
    end
  end

  // Accepts are forced low while reset is held so nothing is consumed.
  assign bus.in_ready_o  = ready & {N_OF_INPUTS{arst_n}};
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_flit_o  = out_flit_q;
  assign bus.busy_o      = (state_q == LOCKED);

endmodule

// File: tb/tb_out_port_arb.sv
// Bench for out_port_arb with four inputs. Sources are fed from per-input
// queues; expected output flits are queued in hand-derived order and a
// monitor pops and compares them whenever the output handshakes.
module tb_out_port_arb;

  localparam int N  = 4;
  localparam int FW = 34;
  localparam logic [1:0] H  = 2'b00;
  localparam logic [1:0] B  = 2'b01;
  localparam logic [1:0] T  = 2'b10;
  localparam logic [1:0] HT = 2'b11;

  logic clk = 1'b0;
  logic arst_n;

  // Clock and reset
  always #5 clk = ~clk;

  out_port_arb_if #(.N_OF_INPUTS(N), .FLIT_WIDTH(FW)) bus ();

  out_port_arb #(.N_OF_INPUTS(N), .FLIT_WIDTH(FW)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus.slave)
  );

  logic [FW-1:0]   src_q [N][$];
  logic [FW-1:0]   exp_q [$];
  logic [N-1:0]    fire;
  logic [N-1:0]    drv_vld;
  logic [N*FW-1:0] drv_flit;
  int total = 0;
  int bad   = 0;

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input int src, input int seq);
    return {t, 16'h0000, 8'(src), 8'(seq)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic put(input int k, input logic [1:0] t, input int seq);
    src_q[k].push_back(mk(t, k, seq));
  endtask

  task automatic want(input int k, input logic [1:0] t, input int seq);
    exp_q.push_back(mk(t, k, seq));
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic step_chk(input string tag, input logic [N-1:0] er, input logic eb);
    #4;
    check({tag, "_ready"}, 64'(bus.in_ready_o), 64'(er));
    check({tag, "_busy"},  64'(bus.busy_o),     64'(eb));
  endtask

  function automatic bit src_busy();
    for (int k = 0; k < N; k++) if (src_q[k].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain;
    int n;
    n = 0;
    bus.out_ready_i = 1'b1;
    while ((exp_q.size() != 0 || src_busy()) && n < 100) begin
      tick();
      n++;
    end
    check("drain_done", 64'(n < 100), 64'd1);
  endtask

  task automatic reset_pulse;
    tick();
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
  endtask

  // Driver: retire accepted flits, present each queue head, note accepts.
  initial begin
    bus.in_valid_i = '0;
    bus.in_flit_i  = '0;
    fire = '0;
    forever begin
      @(negedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (fire[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
      end
      drv_vld  = '0;
      drv_flit = '0;
      for (int k = 0; k < N; k++) begin
        if (src_q[k].size() > 0) begin
          drv_vld[k] = 1'b1;
          drv_flit[k*FW +: FW] = src_q[k][0];
        end
      end
      bus.in_valid_i = drv_vld;
      bus.in_flit_i  = drv_flit;
      #1;
      fire = bus.in_valid_i & bus.in_ready_o;
    end
  end

  // Scoreboard monitor: every output handshake must match the queue head.
  initial begin
    logic [FW-1:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (arst_n && bus.out_valid_o && bus.out_ready_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_unexpected actual=%h required=none t=%0t", bus.out_flit_o, $time);
        end else begin
          e = exp_q.pop_front();
          check("out_flit", 64'(bus.out_flit_o), 64'(e));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // Directed scenarios
  initial begin
    arst_n = 1'b0;
    bus.out_ready_i = 1'b1;

    // Reset state, with a head already waiting on input 1.
    put(1, HT, 0); want(1, HT, 0);
    tick(); tick(); #4;
    check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    check("rst_out_flit",  64'(bus.out_flit_o),  64'd0);
    check("rst_busy",      64'(bus.busy_o),      64'd0);
    check("rst_in_ready",  64'(bus.in_ready_o),  64'd0);
    tick(); arst_n = 1'b1;
    step_chk("rel", 4'b0010, 1'b0);
    drain();

    // Packet interleave on inputs 0 and 1 (mask now favours 2,3 then wraps).
    tick();
    put(0, H, 0); put(0, B, 1); put(0, T, 2);
    put(1, H, 0); put(1, B, 1); put(1, T, 2);
    want(0, H, 0); want(0, B, 1); want(0, T, 2);
    want(1, H, 0); want(1, B, 1); want(1, T, 2);
    step_chk("il0", 4'b0001, 1'b0); tick();
    step_chk("il1", 4'b0001, 1'b1); tick();
    step_chk("il2", 4'b0001, 1'b1); tick();
    step_chk("il3", 4'b0010, 1'b0); tick();
    step_chk("il4", 4'b0010, 1'b1); tick();
    step_chk("il5", 4'b0010, 1'b1); tick();
    step_chk("il6", 4'b0000, 1'b0);
    drain();

    // Fairness: continuous single-flit packets on all inputs.
    reset_pulse();
    tick();
    for (int k = 0; k < N; k++) begin
      put(k, HT, 0); put(k, HT, 1);
    end
    for (int r = 0; r < 2; r++) for (int k = 0; k < N; k++) want(k, HT, r);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      step_chk("fair", 4'(1 << (c % 4)), 1'b0);
    end
    drain();

    // Backpressure: head in the output register, downstream stalls 5 cycles.
    tick();
    put(2, H, 0); put(2, B, 1); put(2, T, 2);
    want(2, H, 0); want(2, B, 1); want(2, T, 2);
    step_chk("bp0", 4'b0100, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.out_ready_i = 1'b0;
      #4;
      check("bp_ready", 64'(bus.in_ready_o),  64'd0);
      check("bp_valid", 64'(bus.out_valid_o), 64'd1);
      check("bp_flit",  64'(bus.out_flit_o),  64'(mk(H, 2, 0)));
      check("bp_busy",  64'(bus.busy_o),      64'd1);
    end
    tick();
    bus.out_ready_i = 1'b1;
    step_chk("bp_rel", 4'b0100, 1'b1);
    drain();

    // Stray BODY on input 1 in IDLE is held; head on input 0 goes through.
    tick();
    put(1, B, 0); put(0, HT, 5); want(0, HT, 5);
    step_chk("stray0", 4'b0001, 1'b0); tick();
    step_chk("stray1", 4'b0000, 1'b0); tick();
    src_q[1].delete();
    drain();

    // Lock exclusivity: input 2 holds the port while input 0 waits.
    tick();
    put(2, H, 0);
    for (int s = 1; s < 10; s++) put(2, B, s);
    put(2, T, 10);
    put(0, H, 0); put(0, T, 1);
    want(2, H, 0);
    for (int s = 1; s < 10; s++) want(2, B, s);
    want(2, T, 10);
    want(0, H, 0); want(0, T, 1);
    for (int c = 0; c < 11; c++) begin
      if (c > 0) tick();
      step_chk("lock", 4'b0100, (c > 0));
    end
    tick(); step_chk("lock_next", 4'b0001, 1'b0);
    tick(); step_chk("lock_next1", 4'b0001, 1'b1);
    drain();

    // Reset mid-packet, asserted away from any clock edge.
    tick();
    put(1, H, 0); put(1, B, 1); put(1, T, 2);
    step_chk("rp0", 4'b0010, 1'b0);
    #3;
    check("rp_busy_pre",  64'(bus.busy_o),      64'd1);
    check("rp_valid_pre", 64'(bus.out_valid_o), 64'd1);
    arst_n = 1'b0;
    #1;
    check("rp_busy",  64'(bus.busy_o),      64'd0);
    check("rp_valid", 64'(bus.out_valid_o), 64'd0);
    check("rp_ready", 64'(bus.in_ready_o),  64'd0);
    src_q[1].delete();
    tick(); tick();
    arst_n = 1'b1;
    put(0, HT, 7); put(3, HT, 7); put(1, B, 1);
    want(0, HT, 7); want(3, HT, 7);
    step_chk("rr0", 4'b0001, 1'b0); tick();
    step_chk("rr1", 4'b1000, 1'b0); tick();
    step_chk("rr2", 4'b0000, 1'b0);
    src_q[1].delete();
    drain();

    check("exp_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/out_port_arb.md
OUT_PORT_ARB -- requirements
Module: out_port_arb

Interface
REQ-001 The module SHALL have parameter N_OF_INPUTS, default 2, giving the number of competing input ports (at least 2).
REQ-002 The module SHALL have parameter FLIT_WIDTH, default 34, giving the flit width; bits [FLIT_WIDTH-1:FLIT_WIDTH-2] hold the flit type.
REQ-003 Port clk: input, 1 bit, the single clock; all state is on its rising edge.
REQ-004 Port arst_n: input, 1 bit, asynchronous active-low reset.
REQ-005 Port in_valid_i: input, N_OF_INPUTS bits, per-input flit valid.
REQ-006 Port in_flit_i: input, N_OF_INPUTS*FLIT_WIDTH bits, per-input flit; input k occupies slice [k*FLIT_WIDTH +: FLIT_WIDTH].
REQ-007 Port in_ready_o: output, N_OF_INPUTS bits, per-input accept; it is combinational and one-hot or zero.
REQ-008 Port out_valid_o: output, 1 bit, registered output flit valid.
REQ-009 Port out_flit_o: output, FLIT_WIDTH bits, registered output flit.
REQ-010 Port out_ready_i: input, 1 bit, downstream accept.
REQ-011 Port busy_o: output, 1 bit, high while a multi-flit packet holds the port (LOCKED state).

Function
REQ-012 Flit type encoding SHALL be: 2'b00 HEAD, 2'b01 BODY, 2'b10 TAIL, 2'b11 HEAD_TAIL (a single-flit packet).
REQ-013 A transfer on input k SHALL occur when in_valid_i[k] and in_ready_o[k] are both high; an output transfer SHALL occur when out_valid_o and out_ready_i are both high.
REQ-014 Load enable SHALL be ld = !out_valid_o || out_ready_i, giving full throughput with no bubble.
REQ-015 The FSM SHALL have two states, IDLE and LOCKED, and busy_o SHALL equal (state == LOCKED).
REQ-016 In IDLE, the request vector SHALL be in_valid_i[k] AND (type is HEAD or HEAD_TAIL); valid BODY or TAIL flits in IDLE SHALL be ignored and held, with ready low.
REQ-017 Round-robin selection in IDLE SHALL work as follows.
- Take mask_req = mask & req.
- If mask_req is nonzero, grant the lowest set index of mask_req; otherwise grant the lowest set index of req.
REQ-018 The mask SHALL be a register, reset to all ones, and it SHALL be updated only when a head flit (HEAD or HEAD_TAIL) from granted input g is transferred.
- The new mask has bits g+1..N_OF_INPUTS-1 set and all others clear.
REQ-019 In IDLE, in_ready_o[g] SHALL equal ld for the granted input g, and all other bits of in_ready_o SHALL be 0.
REQ-020 A HEAD transfer in IDLE SHALL store g in lock_idx and move the FSM to LOCKED at the next edge.
REQ-021 A HEAD_TAIL transfer in IDLE SHALL leave the FSM in IDLE.
REQ-022 In LOCKED, only input lock_idx SHALL be served, with in_ready_o[lock_idx] = ld; valid flits on other inputs SHALL be held.
REQ-023 In LOCKED, every flit type SHALL be forwarded unchanged, and a TAIL transfer SHALL return the FSM to IDLE at the next edge.
- A stray HEAD or HEAD_TAIL arriving in LOCKED SHALL be forwarded as payload and SHALL NOT change the state or the mask.
REQ-024 On an input transfer, out_flit_o and out_valid_o SHALL load the flit and 1 at the next edge, giving 1-cycle latency.
- If ld is high and no input transfers, out_valid_o SHALL clear.
- If ld is low, out_valid_o and out_flit_o SHALL hold.
REQ-025 The TAIL transfer and a new HEAD from any input SHALL NOT both be accepted in the same cycle; the earliest a new head is accepted is the cycle after the TAIL.
REQ-026 If out_ready_i stays low indefinitely, no input flit SHALL be lost or duplicated.

Reset
REQ-027 Assertion of arst_n low SHALL immediately force the following, independent of clk:
- out_valid_o = 0, out_flit_o = 0, busy_o = 0;
- state = IDLE, mask = all ones, lock_idx = 0.
REQ-028 Reset asserted mid-packet SHALL abandon the packet; after release, the block SHALL accept only head flits.
REQ-029 in_ready_o SHALL be 0 while arst_n is low.

Verification
REQ-030 Scenario, N=2, packet interleave:
- Stimulus: both inputs present a 3-flit packet (HEAD, BODY, TAIL) at once, with out_ready_i=1.
- Required response: input 0's three flits, then input 1's three flits, are transferred on consecutive cycles; the first input-1 HEAD is accepted in the cycle after input 0's TAIL.
REQ-031 Scenario, N=4, fairness:
- Stimulus: all four inputs present continuous HEAD_TAIL flits.
- Required response: the grant order is 0,1,2,3,0,1,..., and busy_o stays 0.
REQ-032 Scenario, backpressure:
- Stimulus: a packet is in flight; out_ready_i=0 for 5 cycles.
- Required response: out_valid_o=1 and out_flit_o stay stable, in_ready_o=0, and flit order is unchanged after release.
REQ-033 Scenario, stray non-head flit:
- Stimulus: in IDLE, input 1 presents a BODY flit.
- Required response: in_ready_o[1]=0; a HEAD on input 0 in the same cycle is accepted.
REQ-034 Scenario, reset mid-packet:
- Stimulus: drive arst_n low after a HEAD from input 1, without edge alignment.
- Required response: busy_o=0 and out_valid_o=0 immediately; after release, the next HEAD from input 0 is granted first (mask all ones).
REQ-035 Scenario, lock exclusivity:
- Stimulus: in LOCKED on input 2, input 0 holds a valid HEAD for 10 cycles.
- Required response: in_ready_o[0] stays 0 until input 2's TAIL transfers.
